// File: rtl/system1_kbd_pkg.sv
// Key indices and {ext,code} PS/2 scan codes for the System 1 keypad lines.
// Latency: n/a (constants only).
// Backpressure: n/a.
package system1_kbd_pkg;

    localparam int NUM_KEYS = 25;

    localparam int KEY_0   = 0;
    localparam int KEY_1   = 1;
    localparam int KEY_2   = 2;
    localparam int KEY_3   = 3;
    localparam int KEY_4   = 4;
    localparam int KEY_5   = 5;
    localparam int KEY_6   = 6;
    localparam int KEY_7   = 7;
    localparam int KEY_8   = 8;
    localparam int KEY_9   = 9;
    localparam int KEY_A   = 10;
    localparam int KEY_B   = 11;
    localparam int KEY_C   = 12;
    localparam int KEY_D   = 13;
    localparam int KEY_E   = 14;
    localparam int KEY_F   = 15;
    localparam int KEY_M   = 16;
    localparam int KEY_L   = 17;
    localparam int KEY_G   = 18;
    localparam int KEY_R   = 19;
    localparam int KEY_P   = 20;
    localparam int KEY_UP  = 21;
    localparam int KEY_S   = 22;
    localparam int KEY_DN  = 23;
    localparam int KEY_RST = 24;

    typedef logic [8:0] scan_t;

    // Indexed by key number; bit 8 is the PS/2 extended flag.
    localparam scan_t SCAN_CODES [NUM_KEYS] = '{
        9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D,
        9'h03E, 9'h046, 9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B,
        9'h03A, 9'h04B, 9'h034, 9'h02D, 9'h04D, 9'h175, 9'h01B, 9'h172,
        9'h005
    };

endpackage

// File: rtl/key_stretch.sv
// Per-key hold flag plus minimum-assertion stretch counter.
// Latency: press/release take effect at the edge they are presented; asserted is combinational from state.
// Backpressure: none; every event is consumed on its cycle.
module key_stretch #(
    parameter int HOLD_CYCLES = 500000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic press,
    input  logic release_ev,
    output logic asserted
);

    logic             down;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            down <= 1'b0;
            cnt  <= '0;
        end else if (press) begin
            // A press always reloads, even on the cycle the count would expire.
            down <= 1'b1;
            cnt  <= CNT_W'(HOLD_CYCLES);
        end else begin
            if (release_ev)
                down <= 1'b0;
            if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

    assign asserted = down || (cnt != '0);

endmodule

// File: rtl/system1_keypad.sv
// PS/2 key events to System 1 keypad lines, stretched, merged with on-screen keypad.
// Latency: event at edge N -> sw at edge N+1; osd_sw -> sw in 1 cycle.
// Backpressure: none; hps_io delivers one event per strobe toggle.
module system1_keypad
    import system1_kbd_pkg::*;
#(
    parameter int HOLD_CYCLES = 500000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [10:0]         ps2_key,
    input  logic [NUM_KEYS-1:0] osd_sw,
    output logic [NUM_KEYS-1:0] sw,
    output logic                kbd_active
);

    logic                strobe_q;
    logic                primed;
    logic                evt;
    scan_t               key_code;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] rel;
    logic [NUM_KEYS-1:0] asserted;

    // primed masks the first cycle so a stale strobe level is not taken as an event.
    assign evt      = primed && (ps2_key[10] != strobe_q);
    assign key_code = ps2_key[8:0];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            strobe_q   <= 1'b0;
            primed     <= 1'b0;
            sw         <= '0;
            kbd_active <= 1'b0;
        end else begin
            strobe_q   <= ps2_key[10];
            primed     <= 1'b1;
            sw         <= asserted | osd_sw;
            kbd_active <= |asserted;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic hit;

        assign hit      = (key_code == SCAN_CODES[i]);
        assign press[i] = evt && ps2_key[9] && hit;
        assign rel[i]   = evt && !ps2_key[9] && hit;

        key_stretch #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CNT_W)
        ) u_stretch (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .press      (press[i]),
            .release_ev (rel[i]),
            .asserted   (asserted[i])
        );
    end

endmodule
